// File: rtl/xbee_uart_pkg.sv
// rtl/xbee_uart_pkg.sv - shared constants, state type and width helper for the XBee UART transmitter
package xbee_uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth > 1) ? $clog2(depth) + 1 : 1;
    endfunction

endpackage

// File: rtl/xbee_sync_fifo.sv
// rtl/xbee_sync_fifo.sv - single-clock FIFO with occupancy count, no read bypass
module xbee_sync_fifo
    import xbee_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               push_data,
    input  logic                                push,
    input  logic                                pop,
    output logic [DATA_WIDTH-1:0]               pop_data,
    output logic                                full,
    output logic                                empty,
    output logic [count_width(FIFO_DEPTH)-1:0]  count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = count_width(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0]         wr_q, rd_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push, do_pop;

    assign count    = wr_q - rd_q;
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + CW'(1);
            if (do_pop)  rd_q <= rd_q + CW'(1);
        end
    end

endmodule

// File: rtl/xbee_uart_tx_fifo.sv
// rtl/xbee_uart_tx_fifo.sv - FIFO-buffered serial transmitter with configurable width, parity and stop bits
module xbee_uart_tx_fifo
    import xbee_uart_pkg::*;
#(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               tx_data,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    output logic [count_width(FIFO_DEPTH)-1:0]  fifo_count,
    output logic                                TxD,
    output logic                                TxD_busy
);

    localparam int DIV   = CLKFREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
            $error("xbee_uart_tx_fifo: DATA_WIDTH must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("xbee_uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("xbee_uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (DIV < 2) begin : g_bad_div
            $error("xbee_uart_tx_fifo: CLKFREQ/BAUD must be at least 2");
        end
    endgenerate

    tx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  pop, tick;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;

    xbee_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_data (tx_data),
        .push      (tx_valid),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tick     = (baud_q == CNT_W'(DIV - 1));
    assign tx_ready = !fifo_full;
    assign TxD      = txd_q;
    assign TxD_busy = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        if (state_q != ST_IDLE) begin
            baud_d = tick ? '0 : baud_q + CNT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                pop    = !fifo_empty;
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        // Back-to-back: a queued word starts the next frame with no idle gap.
                        pop     = !fifo_empty;
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            state_d = ST_START;
            baud_d  = '0;
            shift_d = fifo_data;
            par_d   = (PARITY == PARITY_EVEN) ? ^fifo_data : ~^fifo_data;
        end
    end

    // Line level follows the state one clock later, so the start bit falls the edge after the pop.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
            ST_PARITY: txd_d = par_q;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_xbee_uart_tx_fifo.sv
// tb/tb_xbee_uart_tx_fifo.sv - scoreboard bench for three transmitter configurations
module tb_xbee_uart_tx_fifo;

    localparam int NCH = 3;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v0, v1, v2;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [4:0] d2;
    logic       r0, r1, r2;
    logic [4:0] c0;
    logic [2:0] c1;
    logic [3:0] c2;
    logic       t0, t1, t2;
    logic       b0, b1, b2;

    // ch0: 8N1 depth 16, ch1: 7E2 depth 4, ch2: 5O2 depth 8
    xbee_uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .PARITY(0),
                        .STOP_BITS(1), .FIFO_DEPTH(16)) u_ch0 (
        .clk(clk), .reset(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
        .fifo_count(c0), .TxD(t0), .TxD_busy(b0));
    xbee_uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(7), .PARITY(2),
                        .STOP_BITS(2), .FIFO_DEPTH(4)) u_ch1 (
        .clk(clk), .reset(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
        .fifo_count(c1), .TxD(t1), .TxD_busy(b1));
    xbee_uart_tx_fifo #(.CLKFREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(5), .PARITY(1),
                        .STOP_BITS(2), .FIFO_DEPTH(8)) u_ch2 (
        .clk(clk), .reset(rst_n), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
        .fifo_count(c2), .TxD(t2), .TxD_busy(b2));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mq[NCH][$];
    int exp_w[NCH][$];
    int exp_t[NCH][$];
    int free_at[NCH];

    function automatic int dwf(input int ch);  return (ch == 0) ? 8 : (ch == 1) ? 7 : 5; endfunction
    function automatic int parf(input int ch); return (ch == 0) ? 0 : (ch == 1) ? 2 : 1; endfunction
    function automatic int sbf(input int ch);  return (ch == 0) ? 1 : 2; endfunction
    function automatic int depf(input int ch); return (ch == 0) ? 16 : (ch == 1) ? 4 : 8; endfunction
    function automatic int framef(input int ch);
        return (1 + dwf(ch) + ((parf(ch) != 0) ? 1 : 0) + sbf(ch)) * DIV;
    endfunction

    function automatic logic txd(input int ch);  return (ch == 0) ? t0 : (ch == 1) ? t1 : t2; endfunction
    function automatic logic busy(input int ch); return (ch == 0) ? b0 : (ch == 1) ? b1 : b2; endfunction
    function automatic logic rdy(input int ch);  return (ch == 0) ? r0 : (ch == 1) ? r1 : r2; endfunction
    function automatic int cnt(input int ch);
        return (ch == 0) ? int'(c0) : (ch == 1) ? int'(c1) : int'(c2);
    endfunction
    function automatic logic vld(input int ch);  return (ch == 0) ? v0 : (ch == 1) ? v1 : v2; endfunction
    function automatic int dval(input int ch);
        return (ch == 0) ? int'(d0) : (ch == 1) ? int'(d1) : int'(d2);
    endfunction

    task automatic drive(input int ch, input logic v, input int d);
        case (ch)
            0:       begin v0 = v; d0 = 8'(d); end
            1:       begin v1 = v; d1 = 7'(d); end
            default: begin v2 = v; d2 = 5'(d); end
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic string nm(input int ch, input string s);
        return $sformatf("ch%0d_%s", ch, s);
    endfunction

    // Reference model: a word queue per channel, frames of fixed length, one frame at a time.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    mq[ch].delete();
                    exp_w[ch].delete();
                    exp_t[ch].delete();
                    free_at[ch] = 0;
                end
            end else begin
                cyc++;
                for (int ch = 0; ch < NCH; ch++) begin
                    int held;
                    held = mq[ch].size();
                    if (held > 0 && cyc >= free_at[ch]) begin
                        exp_w[ch].push_back(mq[ch].pop_front());
                        exp_t[ch].push_back(cyc + 1);
                        free_at[ch] = cyc + framef(ch);
                    end
                    if (vld(ch) && held < depf(ch)) mq[ch].push_back(dval(ch));
                end
            end
        end
    end

    // Status monitor: occupancy, ready and busy against the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                chk(nm(ch, "fifo_count"), cnt(ch), mq[ch].size());
                chk(nm(ch, "tx_ready"), rdy(ch), (mq[ch].size() < depf(ch)) ? 1 : 0);
                chk(nm(ch, "busy"), busy(ch), (mq[ch].size() > 0 || cyc < free_at[ch]) ? 1 : 0);
            end
        end
    end

    task automatic skip(input int n, inout bit ok);
        for (int i = 0; i < n; i++) begin
            if (ok) begin
                @(negedge clk);
                if (!rst_n) ok = 1'b0;
            end
        end
    endtask

    // Serial monitor: decodes each frame at bit centres and checks it against the scoreboard.
    task automatic mon(input int ch);
        logic       prev;
        logic [8:0] w;
        logic       st, pb, stops;
        bit         ok;
        int         s, ew, et, ones;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
            end else if (prev && !txd(ch)) begin
                s = cyc;
                ok = 1'b1;
                w = '0;
                pb = 1'b0;
                stops = 1'b1;
                skip(DIV / 2, ok);
                st = txd(ch);
                for (int i = 0; i < dwf(ch); i++) begin
                    skip(DIV, ok);
                    w[i] = txd(ch);
                end
                if (parf(ch) != 0) begin
                    skip(DIV, ok);
                    pb = txd(ch);
                end
                for (int k = 0; k < sbf(ch); k++) begin
                    skip(DIV, ok);
                    stops = stops & txd(ch);
                end
                if (ok) begin
                    chk(nm(ch, "frame_expected"), (exp_w[ch].size() > 0) ? 1 : 0, 1);
                    if (exp_w[ch].size() > 0) begin
                        ew = exp_w[ch].pop_front();
                        et = exp_t[ch].pop_front();
                        chk(nm(ch, "start_cycle"), s, et);
                        chk(nm(ch, "start_bit"), st, 0);
                        chk(nm(ch, "data"), w, ew);
                        if (parf(ch) != 0) begin
                            ones = $countones(ew);
                            chk(nm(ch, "parity"), pb, (parf(ch) == 2) ? ones % 2 : 1 - ones % 2);
                        end
                        chk(nm(ch, "stop"), stops, 1);
                    end
                end
                prev = 1'b1;
            end else begin
                prev = txd(ch);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    function automatic bit all_quiet();
        for (int ch = 0; ch < NCH; ch++) begin
            if (mq[ch].size() != 0 || cyc < free_at[ch] + 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!all_quiet() && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_budget", (n < 4000) ? 1 : 0, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int ch = 0; ch < NCH; ch++) drive(ch, 1'b0, 0);
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            chk(nm(ch, "reset_txd"), txd(ch), 1);
            chk(nm(ch, "reset_count"), cnt(ch), 0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single words from idle
        drive(0, 1'b1, 'hA5);
        drive(1, 1'b1, 'h55);
        drive(2, 1'b1, 'h15);
        @(negedge clk);
        idle_inputs();
        drain();

        // Five-word bursts
        for (int i = 0; i < 5; i++) begin
            for (int ch = 0; ch < NCH; ch++) drive(ch, 1'b1, int'($urandom));
            @(negedge clk);
        end
        idle_inputs();
        drain();

        // Random traffic, dense enough to keep the small FIFOs full across pops
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NCH; ch++) drive(ch, ($urandom_range(0, 3) != 0), int'($urandom));
            @(negedge clk);
        end
        idle_inputs();
        drain();

        // Reset in the middle of a three-word burst
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < NCH; ch++) drive(ch, 1'b1, int'($urandom));
            @(negedge clk);
        end
        idle_inputs();
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            chk(nm(ch, "async_reset_txd"), txd(ch), 1);
            chk(nm(ch, "async_reset_busy"), busy(ch), 0);
            chk(nm(ch, "async_reset_count"), cnt(ch), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) drive(ch, 1'b1, int'($urandom));
        @(negedge clk);
        idle_inputs();
        drain();

        for (int ch = 0; ch < NCH; ch++) begin
            chk(nm(ch, "frames_outstanding"), exp_w[ch].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
